// File: rtl/regfile_seq_pkg.sv
// Shared constants for the register-file command sequencer:
// register file geometry, command opcodes and FSM state encoding.
package regfile_seq_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef enum logic [1:0] {
    OP_LOADI = 2'b00,
    OP_COPY  = 2'b01,
    OP_SWAP  = 2'b10,
    OP_ADD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_READ   = 2'b01,
    S_WRITE1 = 2'b10,
    S_WRITE2 = 2'b11
  } state_e;

endpackage

// File: rtl/regfile.sv
// 32 x 32 register file: two combinational read ports, one write port
// committed on the rising edge. r0 is hardwired to zero; writes to it are dropped.
module regfile
  import regfile_seq_pkg::*;
(
  input  logic              Clk,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Write port; register 0 is never stored
  always_ff @(posedge Clk) begin
    if (RegWrite && (WriteRegister != '0))
      regs[WriteRegister] <= WriteData;
  end

  // Combinational read ports with r0 forced to zero
  always_comb begin
    ReadData1 = (ReadRegister1 == '0) ? '0 : regs[ReadRegister1];
    ReadData2 = (ReadRegister2 == '0) ? '0 : regs[ReadRegister2];
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Command sequencer in front of a 2R1W register file. Executes LOADI, COPY,
// SWAP and ADD as short read/write sequences, one command at a time.
// Operands are captured in holdA/holdB during READ, so every write uses
// pre-command values even when the destination aliases a source.
module regfile_sequencer
  import regfile_seq_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [1:0]        CmdOp,
  input  logic [ADDR_W-1:0] CmdRs,
  input  logic [ADDR_W-1:0] CmdRt,
  input  logic [ADDR_W-1:0] CmdRd,
  input  logic [DATA_W-1:0] CmdImm,
  output logic              Done,
  output logic [ADDR_W-1:0] ReadRegister1,
  output logic [ADDR_W-1:0] ReadRegister2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] hold_a, hold_b;

  logic              accept;
  logic              wr_en;
  logic              fin;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign CmdReady = (state_q == S_IDLE);
  assign accept   = CmdValid & CmdReady;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Command latch (rs/rt live directly in the read-address registers) and
  // operand capture at the end of READ
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_q          <= OP_LOADI;
      ReadRegister1 <= '0;
      ReadRegister2 <= '0;
      rd_q          <= '0;
      imm_q         <= '0;
      hold_a        <= '0;
      hold_b        <= '0;
    end else begin
      if (accept) begin
        op_q          <= op_e'(CmdOp);
        ReadRegister1 <= CmdRs;
        ReadRegister2 <= CmdRt;
        rd_q          <= CmdRd;
        imm_q         <= CmdImm;
      end
      if (state_q == S_READ) begin
        hold_a <= ReadData1;
        hold_b <= ReadData2;
      end
    end
  end

  // Next state and write-port selection
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    fin     = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      S_IDLE: begin
        if (accept)
          state_d = (CmdOp == OP_LOADI) ? S_WRITE1 : S_READ;
      end
      S_READ: begin
        state_d = S_WRITE1;
      end
      S_WRITE1: begin
        wr_en = 1'b1;
        case (op_q)
          OP_LOADI: begin wr_addr = rd_q;          wr_data = imm_q;           end
          OP_COPY:  begin wr_addr = rd_q;          wr_data = hold_a;          end
          OP_ADD:   begin wr_addr = rd_q;          wr_data = hold_a + hold_b; end
          OP_SWAP:  begin wr_addr = ReadRegister2; wr_data = hold_a;          end
          default:  begin wr_addr = '0;            wr_data = '0;              end
        endcase
        if (op_q == OP_SWAP) begin
          state_d = S_WRITE2;
        end else begin
          fin     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WRITE2: begin
        wr_en   = 1'b1;
        fin     = 1'b1;
        wr_addr = ReadRegister1;
        wr_data = hold_b;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset masks the write port so nothing commits at a reset edge
  always_comb begin
    RegWrite      = wr_en & ~Reset;
    Done          = fin & ~Reset;
    WriteRegister = Reset ? '0 : wr_addr;
    WriteData     = Reset ? '0 : wr_data;
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench: sequencer driving the regfile, checks on the falling edge.
module tb_regfile_sequencer;
  import regfile_seq_pkg::*;

  logic        Clk, Reset, CmdValid, CmdReady, Done, RegWrite;
  logic [1:0]  CmdOp;
  logic [4:0]  CmdRs, CmdRt, CmdRd, ReadRegister1, ReadRegister2, WriteRegister;
  logic [31:0] CmdImm, ReadData1, ReadData2, WriteData;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int wr_cnt   = 0;
  int snap_done, snap_wr;

  regfile_sequencer dut (
    .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdRs(CmdRs), .CmdRt(CmdRt), .CmdRd(CmdRd), .CmdImm(CmdImm),
    .Done(Done), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .RegWrite(RegWrite)
  );

  regfile u_rf (
    .Clk(Clk), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadData1(ReadData1), .ReadData2(ReadData2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Done)     done_cnt++;
    if (RegWrite) wr_cnt++;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for CmdReady, presents one command for one accept edge, then
  // scrambles the command inputs. Returns just after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] imm);
    int w = 0;
    @(negedge Clk);
    while (!CmdReady && w < 20) begin
      @(negedge Clk);
      w++;
    end
    chk("issue_ready", 32'(CmdReady), 32'd1);
    CmdOp = op; CmdRs = rs; CmdRt = rt; CmdRd = rd; CmdImm = imm;
    CmdValid = 1'b1;
    @(posedge Clk);
    #1;
    CmdValid = 1'b0;
    CmdOp  = ~op;
    CmdRs  = 5'($urandom);
    CmdRt  = 5'($urandom);
    CmdRd  = 5'($urandom);
    CmdImm = $urandom;
  endtask

  task automatic loadi(input logic [4:0] rd, input logic [31:0] imm);
    issue(OP_LOADI, 5'd0, 5'd0, rd, imm);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; CmdValid = 1'b0; CmdOp = '0;
    CmdRs = '0; CmdRt = '0; CmdRd = '0; CmdImm = '0;

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_waddr", 32'(WriteRegister), 32'd0);
    chk("rst_rr1", 32'(ReadRegister1), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("post_rst_ready", 32'(CmdReady), 32'd1);

    // LOADI r5 = DEADBEEF: write one cycle after accept
    issue(OP_LOADI, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF);
    @(negedge Clk);
    chk("loadi_regwrite", 32'(RegWrite), 32'd1);
    chk("loadi_waddr", 32'(WriteRegister), 32'd5);
    chk("loadi_wdata", WriteData, 32'hDEADBEEF);
    chk("loadi_done", 32'(Done), 32'd1);
    chk("loadi_busy", 32'(CmdReady), 32'd0);
    @(negedge Clk);
    chk("loadi_idle_ready", 32'(CmdReady), 32'd1);
    chk("loadi_idle_regwrite", 32'(RegWrite), 32'd0);

    // COPY r5 -> r10
    issue(OP_COPY, 5'd5, 5'd0, 5'd10, 32'h0);
    @(negedge Clk);
    chk("copy_rr1", 32'(ReadRegister1), 32'd5);
    chk("copy_read_r5", ReadData1, 32'hDEADBEEF);
    chk("copy_read_regwrite", 32'(RegWrite), 32'd0);
    chk("copy_read_wdata", WriteData, 32'd0);
    chk("copy_read_done", 32'(Done), 32'd0);
    @(negedge Clk);
    chk("copy_regwrite", 32'(RegWrite), 32'd1);
    chk("copy_waddr", 32'(WriteRegister), 32'd10);
    chk("copy_wdata", WriteData, 32'hDEADBEEF);
    chk("copy_done", 32'(Done), 32'd1);

    // ADD r3 = r3 + r4 with wraparound
    loadi(5'd3, 32'hFFFFFFFF);
    loadi(5'd4, 32'h00000002);
    issue(OP_ADD, 5'd3, 5'd4, 5'd3, 32'h0);
    @(negedge Clk);
    chk("add_read_done", 32'(Done), 32'd0);
    @(negedge Clk);
    chk("add_waddr", 32'(WriteRegister), 32'd3);
    chk("add_wdata", WriteData, 32'h00000001);
    chk("add_done", 32'(Done), 32'd1);
    issue(OP_COPY, 5'd3, 5'd0, 5'd0, 32'h0);
    @(negedge Clk);
    chk("add_r3_after", ReadData1, 32'h00000001);
    @(negedge Clk);

    // SWAP r7 <-> r9
    loadi(5'd7, 32'h11);
    loadi(5'd9, 32'h22);
    issue(OP_SWAP, 5'd7, 5'd9, 5'd0, 32'h0);
    @(negedge Clk);
    chk("swap_c1_ready", 32'(CmdReady), 32'd0);
    chk("swap_c1_regwrite", 32'(RegWrite), 32'd0);
    @(negedge Clk);
    chk("swap_w1_regwrite", 32'(RegWrite), 32'd1);
    chk("swap_w1_waddr", 32'(WriteRegister), 32'd9);
    chk("swap_w1_wdata", WriteData, 32'h11);
    chk("swap_w1_done", 32'(Done), 32'd0);
    chk("swap_w1_ready", 32'(CmdReady), 32'd0);
    @(negedge Clk);
    chk("swap_w2_regwrite", 32'(RegWrite), 32'd1);
    chk("swap_w2_waddr", 32'(WriteRegister), 32'd7);
    chk("swap_w2_wdata", WriteData, 32'h22);
    chk("swap_w2_done", 32'(Done), 32'd1);
    chk("swap_w2_ready", 32'(CmdReady), 32'd0);
    @(negedge Clk);
    chk("swap_end_ready", 32'(CmdReady), 32'd1);
    issue(OP_COPY, 5'd7, 5'd9, 5'd0, 32'h0);
    @(negedge Clk);
    chk("swap_r7_after", ReadData1, 32'h22);
    chk("swap_r9_after", ReadData2, 32'h11);
    @(negedge Clk);

    // COPY r6 -> r0: write issued, r0 still reads zero
    loadi(5'd6, 32'h55);
    issue(OP_COPY, 5'd6, 5'd0, 5'd0, 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    chk("copy_r0_regwrite", 32'(RegWrite), 32'd1);
    chk("copy_r0_waddr", 32'(WriteRegister), 32'd0);
    chk("copy_r0_wdata", WriteData, 32'h55);
    issue(OP_COPY, 5'd0, 5'd0, 5'd0, 32'h0);
    @(negedge Clk);
    chk("r0_reads_zero", ReadData1, 32'h0);
    @(negedge Clk);

    // SWAP with rs == rt: both writes carry the same value
    loadi(5'd12, 32'h77);
    issue(OP_SWAP, 5'd12, 5'd12, 5'd0, 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    chk("swap_same_w1_addr", 32'(WriteRegister), 32'd12);
    chk("swap_same_w1_data", WriteData, 32'h77);
    @(negedge Clk);
    chk("swap_same_w2_addr", 32'(WriteRegister), 32'd12);
    chk("swap_same_w2_data", WriteData, 32'h77);
    chk("swap_same_done", 32'(Done), 32'd1);

    // Reset during WRITE1 of a SWAP: nothing commits, no Done
    loadi(5'd1, 32'hA);
    loadi(5'd2, 32'hB);
    @(negedge Clk);
    snap_done = done_cnt;
    snap_wr   = wr_cnt;
    issue(OP_SWAP, 5'd1, 5'd2, 5'd0, 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("rst_mid_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_mid_done", 32'(Done), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("rst_rel_ready", 32'(CmdReady), 32'd1);
    chk("rst_rel_rr1", 32'(ReadRegister1), 32'd0);
    chk("rst_rel_regwrite", 32'(RegWrite), 32'd0);
    repeat (3) @(negedge Clk);
    chk("rst_no_done", 32'(done_cnt), 32'(snap_done));
    chk("rst_no_write", 32'(wr_cnt), 32'(snap_wr));
    issue(OP_COPY, 5'd1, 5'd2, 5'd0, 32'h0);
    @(negedge Clk);
    chk("rst_r1_kept", ReadData1, 32'hA);
    chk("rst_r2_kept", ReadData2, 32'hB);
    @(negedge Clk);

    // Three LOADIs back to back with CmdValid held high
    @(negedge Clk);
    snap_done = done_cnt;
    snap_wr   = wr_cnt;
    CmdOp = OP_LOADI; CmdRd = 5'd20; CmdImm = 32'd100; CmdValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("q_regwrite", 32'(RegWrite), 32'd1);
      chk("q_waddr", 32'(WriteRegister), 32'(20 + k));
      chk("q_wdata", WriteData, 32'(100 + k));
      chk("q_busy", 32'(CmdReady), 32'd0);
      CmdRd  = 5'(21 + k);
      CmdImm = 32'(101 + k);
      if (k == 2) CmdValid = 1'b0;
      @(negedge Clk);
      chk("q_idle_regwrite", 32'(RegWrite), 32'd0);
      chk("q_idle_ready", 32'(CmdReady), 32'd1);
    end
    chk("q_done_count", 32'(done_cnt - snap_done), 32'd3);
    chk("q_write_count", 32'(wr_cnt - snap_wr), 32'd3);
    issue(OP_COPY, 5'd21, 5'd22, 5'd0, 32'h0);
    @(negedge Clk);
    chk("q_r21", ReadData1, 32'd101);
    chk("q_r22", ReadData2, 32'd102);
    repeat (2) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
